fb_rect_fill: RTL

- Avalon-MM write master that fills a rectangle of the SDRAM framebuffer with one colour.
- Sits upstream of the VGA pixel-buffer DMA in the system clock domain and writes the 16-bit RGB565 back buffer that the DMA scans out.
- The fill colour arrives as 8-bit RGB332 (switch-driven colour input) and is expanded to RGB565 internally.
- One start pulse produces one rectangle, one write per pixel.

---
 rtl/fb_rect_fill_if.sv | 10 +
 rtl/fb_rect_fill.sv | 111 +++++++++++
 2 files changed

// File: rtl/fb_rect_fill_if.sv
// fb_rect_fill_if: Avalon-MM write bus between the rectangle filler and the SDRAM side
interface fb_rect_fill_if;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest;
  modport master(output avm_address, avm_write, avm_writedata, avm_byteenable, input avm_waitrequest);
  modport slave(input avm_address, avm_write, avm_writedata, avm_byteenable, output avm_waitrequest);
endinterface

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: Avalon-MM master filling a framebuffer rectangle with one RGB565 colour
module fb_rect_fill #(
  parameter logic [31:0] FB_BASE = 32'h0000_0000,
  parameter int          H_RES   = 320,
  parameter int          V_RES   = 240,
  parameter int          Y_SHIFT = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          color,
  input  logic [8:0]          x0,
  input  logic [7:0]          y0,
  input  logic [8:0]          x1,
  input  logic [7:0]          y1,
  fb_rect_fill_if.master      avm,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [16:0]         pix_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [8:0] X_MAX = 9'(H_RES - 1);
  localparam logic [7:0] Y_MAX = 8'(V_RES - 1);
  logic [1:0]  state_q, state_d;
  logic [8:0]  cur_x_q, cur_x_d, x0_q, x0_d, x1_q, x1_d;
  logic [7:0]  cur_y_q, cur_y_d, y1_q, y1_d;
  logic [15:0] pix_q, pix_d;
  logic [16:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [8:0]  cx0, cx1;
  logic [7:0]  cy0, cy1;
  logic [15:0] rgb565;
  // clamp the requested corners, expand the colour and advance the raster scan
  always_comb begin
    cx0 = x0 > X_MAX ? X_MAX : x0;
    cx1 = x1 > X_MAX ? X_MAX : x1;
    cy0 = y0 > Y_MAX ? Y_MAX : y0;
    cy1 = y1 > Y_MAX ? Y_MAX : y1;
    rgb565 = {color[7:5], color[7:6], color[4:2], color[4:2], color[1:0], color[1:0], color[1]};
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    pix_d = pix_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE && start) begin
      if (cx0 > cx1 || cy0 > cy1) begin
        state_d = DONE;
        err_d = 1'b1;
      end else begin
        state_d = WRITE;
        err_d = 1'b0;
        x0_d = cx0;
        x1_d = cx1;
        y1_d = cy1;
        cur_x_d = cx0;
        cur_y_d = cy0;
        pix_d = rgb565;
        cnt_d = '0;
      end
    end else if (state_q == WRITE && !avm.avm_waitrequest) begin
      cnt_d = cnt_q + 17'd1;
      if (cur_x_q == x1_q && cur_y_q == y1_q) state_d = DONE;
      else if (cur_x_q == x1_q) begin
        cur_x_d = x0_q;
        cur_y_d = cur_y_q + 8'd1;
      end else cur_x_d = cur_x_q + 9'd1;
    end else if (state_q == DONE) state_d = IDLE;
  end
  // state registers; reset abandons any fill in progress at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      pix_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      pix_q <= pix_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // bus and status outputs decode straight from the registered state
  always_comb begin
    avm.avm_write = state_q == WRITE;
    avm.avm_byteenable = {2{state_q == WRITE}};
    avm.avm_writedata = pix_q;
    avm.avm_address = FB_BASE + ({24'd0, cur_y_q} << Y_SHIFT) + ({23'd0, cur_x_q} << 1);
    busy = state_q == WRITE;
    done = state_q == DONE;
    err = state_q == DONE && err_q;
    pix_count = cnt_q;
  end
endmodule
